mod_mult_check: RTL and testbench

- Sequential 8-bit modular multiplier that computes (x*y) mod p by MSB-first double-and-add, one multiplier bit per cycle.
- Downstream consumer of the modular-inverse engine: takes a value and its claimed inverse and flags whether the product is congruent to 1 mod p.
- Also usable as a general mod-p multiplier for the field-arithmetic datapath.

---
 rtl/mod_arith_pkg.sv | 16 +
 rtl/mod_add_reduce.sv | 21 ++
 rtl/mod_mult_check.sv | 116 +++++++++++
 tb/tb_mod_mult_check.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mod_arith_pkg.sv
// Shared width, FSM encoding and constants for the mod-p multiply/check datapath.
// Pure declarations; no logic, no latency, no flow control.
package mod_arith_pkg;

  localparam int W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Value the product must equal for the inverse pair to be accepted
  localparam int ONE_VAL = 1;

endpackage

// File: rtl/mod_add_reduce.sv
// Combinational (a+b) mod p for a,b < p using a W+1-bit sum and one conditional subtract.
// Zero latency; no flow control.
module mod_add_reduce #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] p,
  output logic [W-1:0] sum
);

  logic [W:0] raw;
  logic [W:0] red;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    red = (raw >= {1'b0, p}) ? (raw - {1'b0, p}) : raw;
    sum = red[W-1:0];
  end

endmodule

// File: rtl/mod_mult_check.sv
// MSB-first double-and-add (x*y) mod p, flags result==1; done W+1 cycles after start (2 on bad operands).
// start is only sampled in IDLE; requests while busy or in the done cycle are dropped, not queued.
module mod_mult_check
  import mod_arith_pkg::*;
#(
  parameter int W = mod_arith_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] prime,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         is_one,
  output logic         err
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t         state;
  logic [W-1:0]   xr;
  logic [W-1:0]   yr;
  logic [W-1:0]   pr;
  logic [W-1:0]   acc;
  logic [CW-1:0]  cnt;
  logic           err_pend;

  logic [W-1:0]   dbl;
  logic [W-1:0]   dbl_add;
  logic [W-1:0]   nxt;
  logic           op_bad;

  mod_add_reduce #(.W(W)) u_dbl (
    .a   (acc),
    .b   (acc),
    .p   (pr),
    .sum (dbl)
  );

  mod_add_reduce #(.W(W)) u_add (
    .a   (dbl),
    .b   (xr),
    .p   (pr),
    .sum (dbl_add)
  );

  assign nxt    = yr[cnt] ? dbl_add : dbl;
  assign op_bad = (prime < W'(2)) || (x >= prime) || (y >= prime);

  // Bad operands still spend one MUL cycle so the error path has a fixed 2-cycle latency
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      xr       <= '0;
      yr       <= '0;
      pr       <= '0;
      acc      <= '0;
      cnt      <= '0;
      err_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      is_one   <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            xr       <= x;
            yr       <= y;
            pr       <= prime;
            acc      <= '0;
            cnt      <= CW'(W - 1);
            err_pend <= op_bad;
            busy     <= 1'b1;
            state    <= MUL;
          end
        end
        MUL: begin
          if (err_pend) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= '0;
            is_one <= 1'b0;
            err    <= 1'b1;
          end else begin
            acc <= nxt;
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= nxt;
              is_one <= (nxt == W'(ONE_VAL));
              err    <= 1'b0;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mult_check.sv
// Directed vector table plus hand sequences for start-while-busy, start-in-done and mid-operation reset.
module tb_mod_mult_check;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] prime;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         is_one;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int x;
    int y;
    int p;
    int res;
    int one;
    int er;
    int lat;
  } vec_t;

  vec_t tbl[12];

  mod_mult_check #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x      (x),
    .y      (y),
    .prime  (prime),
    .busy   (busy),
    .done   (done),
    .result (result),
    .is_one (is_one),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one start pulse and waits for done; lat counts posedges from the sampling edge.
  task automatic run_op(input int xi, input int yi, input int pi,
                        output int lat, output int bcnt, output int got);
    @(negedge clk);
    x = W'(xi); y = W'(yi); prime = W'(pi); start = 1'b1;
    @(posedge clk);
    lat = 1; bcnt = 0; got = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        got = 1;
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, got, pulses, last_res;

    tbl[0]  = '{3,   5,   7,   1,  1, 0, 9};
    tbl[1]  = '{200, 200, 251, 91, 0, 0, 9};
    tbl[2]  = '{2,   126, 251, 1,  1, 0, 9};
    tbl[3]  = '{254, 254, 255, 1,  1, 0, 9};
    tbl[4]  = '{0,   77,  251, 0,  0, 0, 9};
    tbl[5]  = '{7,   3,   7,   0,  0, 1, 2};
    tbl[6]  = '{0,   0,   1,   0,  0, 1, 2};
    tbl[7]  = '{10,  20,  23,  16, 0, 0, 9};
    tbl[8]  = '{5,   0,   13,  0,  0, 0, 9};
    tbl[9]  = '{1,   1,   2,   1,  1, 0, 9};
    tbl[10] = '{2,   4,   3,   0,  0, 1, 2};
    tbl[11] = '{128, 255, 255, 0,  0, 1, 2};

    rst = 1'b1; start = 1'b0; x = '0; y = '0; prime = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy",   int'(busy),   0);
    chk("reset_done",   int'(done),   0);
    chk("reset_result", int'(result), 0);
    chk("reset_is_one", int'(is_one), 0);
    chk("reset_err",    int'(err),    0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_op(tbl[i].x, tbl[i].y, tbl[i].p, lat, bcnt, got);
      chk($sformatf("v%0d_done_seen", i), got, 1);
      chk($sformatf("v%0d_result", i), int'(result), tbl[i].res);
      chk($sformatf("v%0d_is_one", i), int'(is_one), tbl[i].one);
      chk($sformatf("v%0d_err", i),    int'(err),    tbl[i].er);
      chk($sformatf("v%0d_latency", i), lat,  tbl[i].lat);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, tbl[i].lat);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), int'(done), 0);
      chk($sformatf("v%0d_busy_clear", i), int'(busy), 0);
      chk($sformatf("v%0d_result_held", i), int'(result), tbl[i].res);
    end

    // start held high, then new operands presented while MUL is running
    @(negedge clk);
    x = 8'd3; y = 8'd5; prime = 8'd7; start = 1'b1;
    pulses = 0; last_res = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 2) begin x = 8'd4; y = 8'd6; end
      if (i == 5) start = 1'b0;
      if (done) begin
        pulses++;
        last_res = int'(result);
      end
    end
    chk("held_start_pulses", pulses, 1);
    chk("held_start_result", last_res, 1);

    // start raised during the DONE cycle must be dropped, then taken in IDLE
    run_op(3, 5, 7, lat, bcnt, got);
    chk("dstart_first_done", got, 1);
    x = 8'd4; y = 8'd6; prime = 8'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("dstart_ignored_busy", int'(busy), 0);
    chk("dstart_ignored_done", int'(done), 0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("dstart_accepted_busy", int'(busy), 1);
    chk("dstart_result_stable", int'(result), 1);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("dstart_second_done", got, 1);
    chk("dstart_second_result", int'(result), 3);

    // reset during the fourth MUL cycle
    @(negedge clk);
    x = 8'd3; y = 8'd5; prime = 8'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy",   int'(busy),   0);
    chk("midrst_done",   int'(done),   0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_is_one", int'(is_one), 0);
    chk("midrst_err",    int'(err),    0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("midrst_no_activity", pulses, 0);

    run_op(200, 200, 251, lat, bcnt, got);
    chk("post_rst_done_seen", got, 1);
    chk("post_rst_result", int'(result), 91);
    chk("post_rst_latency", lat, 9);
    run_op(3, 5, 7, lat, bcnt, got);
    chk("post_rst2_done_seen", got, 1);
    chk("post_rst2_result", int'(result), 1);
    chk("post_rst2_is_one", int'(is_one), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
